// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: valid/ready read requests
// plus the tagged one-cycle response strobe.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM among NUM_REQ
// requesters; one read per clock, responses two cycles after the grant.
module rom_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rom_read_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  o_rom_address,
  input  logic [DATA_W-1:0]  i_rom_data,
  output logic               o_busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr, r_s1_tag, r_s2_tag;
  logic               r_s1_valid, r_s2_valid;
  logic [PTR_W-1:0]   w_idx, w_nxt;
  logic [PTR_W:0]     w_j;
  logic               w_found;
  logic [ADDR_W-1:0]  w_addr;
  logic [NUM_REQ-1:0] w_grant, w_rsp;

  // Rotating priority scan starting at the pointer; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_addr  = '0;
    w_j     = '0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_j >= (PTR_W+1)'(NUM_REQ)) w_j = w_j - (PTR_W+1)'(NUM_REQ);
      if (!w_found && bus.req_valid[w_j[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_j[PTR_W-1:0];
      end
    end
    for (int k = 0; k < NUM_REQ; k++)
      if (w_idx == PTR_W'(k)) w_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
    if (i_rst) w_found = 1'b0;
    if (w_found) w_grant[w_idx] = 1'b1;
  end

  assign w_nxt         = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
  assign bus.req_ready = w_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rom_address <= '0;
      r_ptr         <= '0;
      r_s1_valid    <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s1_tag      <= '0;
      r_s2_tag      <= '0;
    end else begin
      r_s1_valid <= w_found;
      if (w_found) begin
        o_rom_address <= w_addr;
        r_s1_tag      <= w_idx;
        r_ptr         <= w_nxt;
      end
      // Stage 2 lines up with the ROM's own output register.
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
    end
  end

  always_comb begin
    w_rsp = '0;
    if (r_s2_valid) w_rsp[r_s2_tag] = 1'b1;
  end

  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_data  = r_s2_valid ? i_rom_data : '0;
  assign o_busy        = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a golden synchronous ROM.
module tb_rom_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic              busy;

  always #5 clk = ~clk;

  rom_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_rom_address (rom_address),
    .i_rom_data    (rom_data),
    .o_busy        (busy)
  );

  // Bijective content so distinct addresses never alias.
  function automatic logic [7:0] gold(input logic [6:0] a);
    return (8'(a) * 8'd37) ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_data <= gold(rom_address);

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] a_drv [4];
  logic       e1v = 1'b0, e2v = 1'b0;
  int         e1t = 0, e2t = 0;
  logic [6:0] e1a = '0, e2a = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive at posedge+1, sample at negedge, advance expected pipeline.
  task automatic cycle(input logic [3:0] v, input logic [3:0] exp_rdy, input string tag);
    logic [3:0] exp_rv;
    bus.req_valid = v;
    bus.req_addr  = {a_drv[3], a_drv[2], a_drv[1], a_drv[0]};
    @(negedge clk);
    exp_rv = e2v ? (4'b0001 << e2t) : 4'b0000;
    chk({tag, " ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_rv));
    chk({tag, " rsp_data"}, 32'(bus.rsp_data), e2v ? 32'(gold(e2a)) : 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'(e1v | e2v));
    e2v = e1v; e2t = e1t; e2a = e1a;
    e1v = |exp_rdy;
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) begin e1t = i; e1a = a_drv[i]; end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_drv[0] = 7'd5; a_drv[1] = 7'd6; a_drv[2] = 7'd7; a_drv[3] = 7'd8;
    bus.req_valid = 4'hF;
    bus.req_addr  = '0;
    @(posedge clk); #1;

    // Reset held with everyone requesting
    repeat (3) begin
      cycle(4'hF, 4'h0, "reset");
      chk("reset rom_address", 32'(rom_address), 32'd0);
    end
    rst = 1'b0;
    cycle(4'hF, 4'b0001, "first grant");
    chk("first rom_address", 32'(rom_address), 32'd5);
    cycle(4'h0, 4'h0, "drain0");
    cycle(4'h0, 4'h0, "drain0");
    cycle(4'h0, 4'h0, "idle0");

    // Requester 2 alone sweeps the full address range back-to-back
    for (int t = 0; t < 128; t++) begin
      a_drv[2] = 7'(t);
      cycle(4'b0100, 4'b0100, "sweep");
    end
    cycle(4'h0, 4'h0, "sweep drain");
    cycle(4'h0, 4'h0, "sweep drain");
    cycle(4'h0, 4'h0, "sweep idle");

    // Pointer sits at 3 after the last grant to 2
    a_drv[0] = 7'd50; a_drv[3] = 7'd60;
    cycle(4'b1001, 4'b1000, "sparse g3");
    cycle(4'b1001, 4'b0001, "sparse g0");
    cycle(4'b1001, 4'b1000, "sparse g3b");
    cycle(4'h0, 4'h0, "sparse drain");
    cycle(4'h0, 4'h0, "sparse drain");

    // Round robin with all four holding requests
    a_drv[0] = 7'd10; a_drv[1] = 7'd20; a_drv[2] = 7'd30; a_drv[3] = 7'd40;
    for (int r = 0; r < 2; r++) begin
      cycle(4'hF, 4'b0001, "rr g0");
      cycle(4'hF, 4'b0010, "rr g1");
      cycle(4'hF, 4'b0100, "rr g2");
      cycle(4'hF, 4'b1000, "rr g3");
    end
    cycle(4'h0, 4'h0, "rr drain");
    cycle(4'h0, 4'h0, "rr drain");

    // Boundary addresses from requester 1
    a_drv[1] = 7'd127;
    cycle(4'b0010, 4'b0010, "bnd 127");
    a_drv[1] = 7'd0;
    cycle(4'b0010, 4'b0010, "bnd 0");
    cycle(4'h0, 4'h0, "bnd drain");
    cycle(4'h0, 4'h0, "bnd drain");

    // Reset while two reads are in flight (pointer at 2 here)
    a_drv[0] = 7'd33; a_drv[1] = 7'd44;
    cycle(4'b0001, 4'b0001, "mid g0");
    cycle(4'b0010, 4'b0010, "mid g1");
    rst = 1'b1;
    cycle(4'h0, 4'h0, "mid rst edge");
    e1v = 1'b0; e2v = 1'b0;
    cycle(4'hF, 4'h0, "mid post rst");
    chk("mid rom_address", 32'(rom_address), 32'd0);
    rst = 1'b0;
    cycle(4'hF, 4'b0001, "mid ptr0");
    cycle(4'h0, 4'h0, "mid drain");
    cycle(4'h0, 4'h0, "mid drain");
    cycle(4'h0, 4'h0, "mid idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
